shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
- Pipelined, parametrised successor to the single-cycle combinational shift unit in the RISC-V execute path.
- Performs SLL/SRL/SRA on XLEN-bit operands.
- When XLEN=64, also performs the RV64 word forms SLLW/SRLW/SRAW.
- Barrel levels are spread over STAGES register slices with a valid/ready handshake on both sides, so it can sit behind the issue stage and stall under writeback backpressure.

Parameters:
- XLEN, 32, operand width; legal values 32 or 64.
- STAGES, 2, number of pipeline register slices; legal range 1..log2(XLEN).
- TAG_W, 5, width of the opaque tag carried alongside each op (e.g. destination register).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- Flush  in  1  discard every in-flight op.
- In_Valid  in  1  op presented.
- In_Ready  out  1  op accepted when In_Valid && In_Ready.
- Src1  in  XLEN  value to shift.
- Src2  in  log2(XLEN)  shift amount.
- Funct3_2  in  1  0 = left, 1 = right.
- Funct7_5  in  1  1 = arithmetic (right shifts only).
- Word_Mode  in  1  RV64 *W op; ignored when XLEN=32.
- Rot  in  1  rotate select; see Optional Feature.
- In_Tag  in  TAG_W  tag travelling with the op.
- Out_Valid  out  1  result available.
- Out_Ready  in  1  consumer accepts.
- Result  out  XLEN  shifted value.
- Out_Tag  out  TAG_W  tag of the result.

Behaviour:
- Op decode:
  - Funct3_2=0 → SLL; Funct7_5 is ignored.
  - Funct3_2=1, Funct7_5=0 → SRL.
  - Funct3_2=1, Funct7_5=1 → SRA.
- Datapath:
  - Right-shift-only barrel.
  - Left shifts bit-reverse the operand on entry to stage 0 and bit-reverse the result at the final stage.
  - Fill bit = operand MSB for SRA, otherwise 0.
- Level distribution:
  - There are L = log2(XLEN) levels; level j shifts by 2^j.
  - Stage s implements levels [s*ceil(L/STAGES), min(L,(s+1)*ceil(L/STAGES))-1].
  - The remaining shift amount, fill bit, direction, word flag and tag travel with the data.
- Word mode (XLEN=64):
  - Operand is Src1[31:0]; for SRAW the fill bit is Src1[31].
  - Shift amount is Src2[4:0]; Src2[5] is ignored.
  - Result = sign-extension of bit 31 of the 32-bit result to 64 bits.
- Latency and throughput:
  - Op accepted in cycle t presents Out_Valid in cycle t+STAGES.
  - Throughput is one op per cycle while Out_Ready=1.
  - Results leave in acceptance order.
- Handshake:
  - Each stage holds a valid bit.
  - A stage advances when its successor is empty or is itself advancing; the last stage advances on Out_Ready.
  - In_Ready = !valid[0] || advance[0]; it is combinational from Out_Ready through the chain.
  - While Out_Valid && !Out_Ready, Result and Out_Tag are held stable.
  - Stage data registers load only when their stage accepts.
- Flush:
  - All valid bits clear on the next edge.
  - In_Ready is forced 0 during the Flush cycle, so an In_Valid presented in that cycle is not accepted.
  - Out_Valid may still be high in the Flush cycle, but a handshake in that cycle is ignored by the consumer; Flush dominates.
- Reset:
  - RST has priority over Flush and the handshake.
  - All valid bits clear; Result=0 and Out_Tag=0; In_Ready=1 from the first cycle after RST deasserts.
  - Reset mid-operation drops all in-flight ops with no partial output.
- Boundary cases:
  - Shift amount 0 returns Src1 unchanged (word mode: sign-extended low word).
  - Shift amount XLEN-1 is legal.
  - Simultaneous accept and output handshake when full is legal and sustains full rate.

Optional Feature:
- Macro SHIFT_ROTATE_EN.
- Defined:
  - Rot=1 selects ROL (Funct3_2=0) or ROR (Funct3_2=1); Funct7_5 is ignored.
  - Fill comes from the bits shifted out: each level is a rotate, not a fill.
  - Word mode rotates within the low 32 bits, then sign-extends bit 31 (ROLW/RORW).
- Undefined: Rot is ignored (treated as 0), no rotate muxes are built, and the port remains for interface stability.

Decomposition:
- Package shift_pkg holds:
  - localparam function for shift-amount width (clog2).
  - Levels-per-stage constant.
  - Op-decode constants: LEFT/RIGHT, LOGIC/ARITH, ROT.
  - Bit-reverse function.
- Sub-module shift_stage holds one register slice:
  - parameters: first level, level count;
  - handshake: valid in/out, advance;
  - payload: data, remaining amount, fill, flags, tag.
  - shift_pipe instantiates STAGES of these with generate and adds the word-mode pre/post logic.

Test Plan:
1. XLEN=64, STAGES=3: SLL, Src1=0x1, Src2=63 → Result=0x8000000000000000, Out_Valid exactly 3 cycles after accept.
2. SRA Src1=0x8000000000000000, Src2=4 → 0xF800000000000000; same operands with SRL → 0x0800000000000000; Src2=0 → Src1 unchanged.
3. Word_Mode=1:
   - SRAW Src1=0x0000000080000000, Src2=36 → 0xFFFFFFFFF8000000.
   - SLLW Src1=0x1, Src2=31 → 0xFFFFFFFF80000000.
   - SRLW Src1=0xFFFFFFFF00000010, Src2=4 → 0x1.
4. Backpressure:
   - Stimulus: 6 back-to-back ops, tags 0..5; Out_Ready low for 5 cycles starting at the first Out_Valid.
   - Expected: In_Ready drops once 3 are held; Result and Out_Tag stable while stalled; tags emerge 0..5 in order with no loss or duplication.
5. Flush and reset:
   - Flush with 2 ops in flight, plus In_Valid in the same cycle → no outputs, In_Ready=0 that cycle; the next op completes normally.
   - RST mid-stream → Out_Valid=0, Result=0 next cycle.
6. Rotate:
   - With SHIFT_ROTATE_EN: ROR Src1=0x1, Src2=1 → 0x8000000000000000; RORW Src1=0x1, Src2=1 → 0xFFFFFFFF80000000.
   - Without the macro, the same ROR stimulus gives SRL → 0x0.

Source files
------------

// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : shared constants and helpers for the pipelined shift unit
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_pkg;

   localparam int MAX_XLEN = 64;

   // Op-decode encodings of Funct3_2 / Funct7_5 / Rot
   localparam logic DIR_LEFT   = 1'b0;
   localparam logic DIR_RIGHT  = 1'b1;
   localparam logic KIND_LOGIC = 1'b0;
   localparam logic KIND_ARITH = 1'b1;
   localparam logic ROT_SEL    = 1'b1;

   function automatic int shift_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int lvls_per_stage(input int levels, input int stages);
      return (levels + stages - 1) / stages;
   endfunction

   // Reverses the low w bits of v; bits above w are returned as zero
   function automatic logic [MAX_XLEN-1:0] bit_rev(input logic [MAX_XLEN-1:0] v, input int w);
      logic [MAX_XLEN-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_XLEN; i++) begin
         if (i < w) r[i] = v[w-1-i];
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
// ============================================================================
// shift_stage : one register slice of the right-shift barrel, holding a
//               contiguous group of levels plus the op payload.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_stage #(
   parameter int XLEN      = 32,
   parameter int SHAMT_W   = 5,
   parameter int TAG_W     = 5,
   parameter int FIRST_LVL = 0,
   parameter int NUM_LVL   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_flush,
   input  logic               i_valid,
   input  logic               i_ready,
   input  logic               i_down_ready,
   input  logic [XLEN-1:0]    i_data,
   input  logic [SHAMT_W-1:0] i_amt,
   input  logic               i_fill,
   input  logic               i_left,
   input  logic               i_word,
   input  logic               i_rot,
   input  logic [TAG_W-1:0]   i_tag,
   output logic               o_valid,
   output logic [XLEN-1:0]    o_data,
   output logic [SHAMT_W-1:0] o_amt,
   output logic               o_fill,
   output logic               o_left,
   output logic               o_word,
   output logic               o_rot,
   output logic [TAG_W-1:0]   o_tag
);

   logic               r_valid;
   logic [XLEN-1:0]    r_data;
   logic [SHAMT_W-1:0] r_amt;
   logic               r_fill;
   logic               r_left;
   logic               r_word;
   logic               r_rot;
   logic [TAG_W-1:0]   r_tag;

   logic               w_accept;
   logic               w_advance;
   logic [XLEN-1:0]    w_lvl [0:NUM_LVL];

   assign w_lvl[0] = i_data;

   for (genvar j = 0; j < NUM_LVL; j++) begin : g_lvl
      localparam int LVL = FIRST_LVL + j;
      localparam int K   = 1 << LVL;
      logic [XLEN-1:0] w_in_hi;
`ifdef SHIFT_ROTATE_EN
      // A rotate refills the vacated top bits with the bits dropped off the bottom
      assign w_in_hi = i_rot ? (w_lvl[j] << (XLEN - K)) : ({XLEN{i_fill}} << (XLEN - K));
`else
      assign w_in_hi = {XLEN{i_fill}} << (XLEN - K);
`endif
      assign w_lvl[j+1] = i_amt[LVL] ? (w_in_hi | (w_lvl[j] >> K)) : w_lvl[j];
   end

   assign w_accept  = i_valid && i_ready;
   assign w_advance = r_valid && i_down_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_amt   <= '0;
         r_fill  <= 1'b0;
         r_left  <= 1'b0;
         r_word  <= 1'b0;
         r_rot   <= 1'b0;
         r_tag   <= '0;
      end else begin
         if (i_flush)        r_valid <= 1'b0;
         else if (w_accept)  r_valid <= 1'b1;
         else if (w_advance) r_valid <= 1'b0;

         if (w_accept) begin
            r_data <= w_lvl[NUM_LVL];
            r_amt  <= i_amt;
            r_fill <= i_fill;
            r_left <= i_left;
            r_word <= i_word;
            r_rot  <= i_rot;
            r_tag  <= i_tag;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_amt   = r_amt;
   assign o_fill  = r_fill;
   assign o_left  = r_left;
   assign o_word  = r_word;
   assign o_rot   = r_rot;
   assign o_tag   = r_tag;

endmodule

`default_nettype wire

// File: rtl/shift_pipe.sv
// ============================================================================
// shift_pipe : pipelined SLL/SRL/SRA (+ RV64 W forms) with valid/ready on both
//              sides. Optional ROL/ROR under macro SHIFT_ROTATE_EN.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_pipe
   import shift_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          Flush,
   input  logic                          In_Valid,
   output logic                          In_Ready,
   input  logic [XLEN-1:0]               Src1,
   input  logic [shift_clog2(XLEN)-1:0]  Src2,
   input  logic                          Funct3_2,
   input  logic                          Funct7_5,
   input  logic                          Word_Mode,
   input  logic                          Rot,
   input  logic [TAG_W-1:0]              In_Tag,
   output logic                          Out_Valid,
   input  logic                          Out_Ready,
   output logic [XLEN-1:0]               Result,
   output logic [TAG_W-1:0]              Out_Tag
);

   localparam int SHAMT_W = shift_clog2(XLEN);
   localparam int LPS     = lvls_per_stage(SHAMT_W, STAGES);

   logic [XLEN-1:0]    w_data [0:STAGES];
   logic [SHAMT_W-1:0] w_amt  [0:STAGES];
   logic               w_fill [0:STAGES];
   logic               w_left [0:STAGES];
   logic               w_word [0:STAGES];
   logic               w_rot  [0:STAGES];
   logic [TAG_W-1:0]   w_tag  [0:STAGES];
   logic [STAGES-1:0]  w_vld;
   logic [STAGES:0]    w_vin;
   logic [STAGES:0]    w_rdy;

   logic               w_rot0;
   logic               w_arith;
   logic               w_fill0;
   logic               w_word0;
   logic [XLEN-1:0]    w_pre;
   logic [SHAMT_W-1:0] w_amt0;
   logic [XLEN-1:0]    w_fin;
   logic               w_unused_tail;

`ifdef SHIFT_ROTATE_EN
   assign w_rot0 = (Rot == ROT_SEL);
`else
   logic w_unused_rot;
   assign w_rot0       = 1'b0;
   assign w_unused_rot = Rot;
`endif

   assign w_arith = (Funct3_2 == DIR_RIGHT) && (Funct7_5 == KIND_ARITH) && !w_rot0;

   if (XLEN == 64) begin : g_word64
      // Word ops: a doubled low word makes a 64-bit rotate behave as a 32-bit one
      always_comb begin
         if (Word_Mode) begin
            w_fill0 = w_arith && Src1[31];
            w_pre   = w_rot0 ? {Src1[31:0], Src1[31:0]} : {{32{w_fill0}}, Src1[31:0]};
            w_amt0  = {1'b0, Src2[4:0]};
         end else begin
            w_fill0 = w_arith && Src1[XLEN-1];
            w_pre   = Src1;
            w_amt0  = Src2;
         end
      end
      assign w_word0 = Word_Mode;
      assign Result  = w_word[STAGES] ? {{32{w_fin[31]}}, w_fin[31:0]} : w_fin;
   end else begin : g_word32
      logic w_unused_word;
      assign w_fill0       = w_arith && Src1[XLEN-1];
      assign w_pre         = Src1;
      assign w_amt0        = Src2;
      assign w_word0       = 1'b0;
      assign Result        = w_fin;
      assign w_unused_word = Word_Mode ^ w_word[STAGES];
   end

   assign w_data[0] = (Funct3_2 == DIR_LEFT) ? XLEN'(bit_rev(MAX_XLEN'(w_pre), XLEN)) : w_pre;
   assign w_amt[0]  = w_amt0;
   assign w_fill[0] = w_fill0;
   assign w_left[0] = (Funct3_2 == DIR_LEFT);
   assign w_word[0] = w_word0;
   assign w_rot[0]  = w_rot0;
   assign w_tag[0]  = In_Tag;

   // Stage s can take a new op if any slot from s to the output is free,
   // or the output slot drains this cycle.
   for (genvar s = 0; s < STAGES; s++) begin : g_rdy
      assign w_rdy[s] = !RST && !Flush && (!(&w_vld[STAGES-1:s]) || Out_Ready);
   end
   assign w_rdy[STAGES] = Out_Ready;
   assign w_vin         = {w_vld, In_Valid};

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int FIRST = s * LPS;
      localparam int LAST  = ((s + 1) * LPS < SHAMT_W) ? (s + 1) * LPS : SHAMT_W;
      localparam int NUM   = (LAST > FIRST) ? (LAST - FIRST) : 0;

      shift_stage #(
         .XLEN      (XLEN),
         .SHAMT_W   (SHAMT_W),
         .TAG_W     (TAG_W),
         .FIRST_LVL (FIRST),
         .NUM_LVL   (NUM)
      ) u_stage (
         .clk          (CLK),
         .rst          (RST),
         .i_flush      (Flush),
         .i_valid      (w_vin[s]),
         .i_ready      (w_rdy[s]),
         .i_down_ready (w_rdy[s+1]),
         .i_data       (w_data[s]),
         .i_amt        (w_amt[s]),
         .i_fill       (w_fill[s]),
         .i_left       (w_left[s]),
         .i_word       (w_word[s]),
         .i_rot        (w_rot[s]),
         .i_tag        (w_tag[s]),
         .o_valid      (w_vld[s]),
         .o_data       (w_data[s+1]),
         .o_amt        (w_amt[s+1]),
         .o_fill       (w_fill[s+1]),
         .o_left       (w_left[s+1]),
         .o_word       (w_word[s+1]),
         .o_rot        (w_rot[s+1]),
         .o_tag        (w_tag[s+1])
      );
   end

   assign w_fin = w_left[STAGES] ? XLEN'(bit_rev(MAX_XLEN'(w_data[STAGES]), XLEN)) : w_data[STAGES];

   assign In_Ready  = w_rdy[0];
   assign Out_Valid = w_vld[STAGES-1];
   assign Out_Tag   = w_tag[STAGES];

   assign w_unused_tail = ^{w_amt[STAGES], w_fill[STAGES], w_rot[STAGES]};

endmodule

`default_nettype wire

// File: tb/tb_shift_pipe.sv
// ============================================================================
// tb_shift_pipe : directed + randomized checks of shift_pipe (XLEN=64, STAGES=3)
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_pipe;

   localparam int XLEN   = 64;
   localparam int STAGES = 3;
   localparam int TAG_W  = 5;

   logic             CLK = 1'b0;
   logic             RST, Flush, In_Valid, In_Ready;
   logic [XLEN-1:0]  Src1;
   logic [5:0]       Src2;
   logic             Funct3_2, Funct7_5, Word_Mode, Rot;
   logic [TAG_W-1:0] In_Tag, Out_Tag;
   logic             Out_Valid, Out_Ready;
   logic [XLEN-1:0]  Result;

   shift_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .CLK(CLK), .RST(RST), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .Src1(Src1), .Src2(Src2), .Funct3_2(Funct3_2), .Funct7_5(Funct7_5),
      .Word_Mode(Word_Mode), .Rot(Rot), .In_Tag(In_Tag), .Out_Valid(Out_Valid),
      .Out_Ready(Out_Ready), .Result(Result), .Out_Tag(Out_Tag)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [63:0]      res;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t        expq[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_out    = 0;
   int          cyc      = 0;
   int          last_acc_cyc = 0;
   logic [4:0]  tag_ctr  = 5'd0;
   bit          done     = 1'b0;
   bit          stall_prev = 1'b0;
   logic [63:0] prev_res;
   logic [TAG_W-1:0] prev_tag;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", nm, got, exp);
      end
   endtask

   // Reference: RISC-V shift semantics written with plain operators
   function automatic logic [63:0] model(input logic [63:0] s1, input logic [5:0] s2,
                                         input logic f3, input logic f7,
                                         input logic wm, input logic rt);
      logic        rot;
      logic [31:0] x, r32;
      logic [63:0] r64;
      int          n;
`ifdef SHIFT_ROTATE_EN
      rot = rt;
`else
      rot = rt & 1'b0;
`endif
      if (wm) begin
         x = s1[31:0];
         n = int'(s2[4:0]);
         if (rot)     r32 = f3 ? ((x >> n) | (x << (32 - n))) : ((x << n) | (x >> (32 - n)));
         else if (!f3) r32 = x << n;
         else if (f7)  r32 = 32'($signed(x) >>> n);
         else          r32 = x >> n;
         return {{32{r32[31]}}, r32};
      end
      n = int'(s2);
      if (rot)     r64 = f3 ? ((s1 >> n) | (s1 << (64 - n))) : ((s1 << n) | (s1 >> (64 - n)));
      else if (!f3) r64 = s1 << n;
      else if (f7)  r64 = 64'($signed(s1) >>> n);
      else          r64 = s1 >> n;
      return r64;
   endfunction

   // Scoreboard: record accepts, check outputs in order, check stall stability
   always @(negedge CLK) begin
      if (RST || Flush) begin
         expq.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid_held", 64'(Out_Valid), 64'd1);
            chk("stall_result_held", Result, prev_res);
            chk("stall_tag_held", 64'(Out_Tag), 64'(prev_tag));
         end
         if (Out_Valid && Out_Ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_output", 64'(Out_Tag), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("result_vs_model", Result, e.res);
               chk("tag_order", 64'(Out_Tag), 64'(e.tag));
               n_out++;
            end
         end
         if (In_Valid && In_Ready)
            expq.push_back('{model(Src1, Src2, Funct3_2, Funct7_5, Word_Mode, Rot), In_Tag});
         stall_prev = Out_Valid && !Out_Ready;
         prev_res   = Result;
         prev_tag   = Out_Tag;
      end
   end

   task automatic send(input logic [63:0] s1, input logic [5:0] s2, input logic f3,
                       input logic f7, input logic wm, input logic rt, input logic [4:0] tg);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      Src1 = s1; Src2 = s2; Funct3_2 = f3; Funct7_5 = f7; Word_Mode = wm; Rot = rt;
      In_Tag = tg; In_Valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge CLK);
         acc = In_Ready;
         if (acc) last_acc_cyc = cyc;
         @(posedge CLK); #1;
         n++;
      end
      In_Valid = 1'b0;
      if (!acc) chk("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic run_one(input string nm, input logic [63:0] s1, input logic [5:0] s2,
                          input logic f3, input logic f7, input logic wm, input logic rt,
                          input logic [63:0] exp);
      int n;
      n = 0;
      send(s1, s2, f3, f7, wm, rt, tag_ctr);
      tag_ctr++;
      do begin
         @(negedge CLK);
         n++;
      end while (!Out_Valid && n < 20);
      chk({nm, "_valid"}, 64'(Out_Valid), 64'd1);
      chk({nm, "_latency"}, 64'(cyc - last_acc_cyc), 64'(STAGES));
      chk(nm, Result, exp);
      @(posedge CLK); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, base, seen;
      RST = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Src1 = '0; Src2 = '0;
      Funct3_2 = 1'b0; Funct7_5 = 1'b0; Word_Mode = 1'b0; Rot = 1'b0; In_Tag = '0;
      Out_Ready = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_out_valid", 64'(Out_Valid), 64'd0);
      chk("reset_result", Result, 64'd0);
      chk("reset_out_tag", 64'(Out_Tag), 64'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("reset_in_ready", 64'(In_Ready), 64'd1);
      @(posedge CLK); #1;

      run_one("sll_63", 64'h1, 6'd63, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000);
      run_one("sra_4", 64'h8000_0000_0000_0000, 6'd4, 1'b1, 1'b1, 1'b0, 1'b0, 64'hF800_0000_0000_0000);
      run_one("srl_4", 64'h8000_0000_0000_0000, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0800_0000_0000_0000);
      run_one("srl_0", 64'h0123_4567_89AB_CDEF, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);
      run_one("sll_0", 64'hFEDC_BA98_7654_3210, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFEDC_BA98_7654_3210);
      run_one("sraw_36", 64'h0000_0000_8000_0000, 6'd36, 1'b1, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_F800_0000);
      run_one("sllw_31", 64'h1, 6'd31, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000);
      run_one("srlw_4", 64'hFFFF_FFFF_0000_0010, 6'd4, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1);
`ifdef SHIFT_ROTATE_EN
      run_one("ror_1", 64'h1, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000);
      run_one("rorw_1", 64'h1, 6'd1, 1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000);
      run_one("rol_4", 64'hF000_0000_0000_0001, 6'd4, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_001F);
`else
      run_one("ror_off_1", 64'h1, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0);
      run_one("rorw_off_1", 64'h1, 6'd1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
`endif

      // Backpressure: 6 back-to-back ops, consumer stalls 5 cycles from first Out_Valid
      base = n_out;
      Out_Ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(64'h1 << (4 * i), 6'(i), 1'b0, 1'b0, 1'b0, 1'b0, 5'(i));
         end
         begin
            n = 0;
            do begin
               @(negedge CLK);
               n++;
            end while (!Out_Valid && n < 20);
            chk("bp_first_valid", 64'(Out_Valid), 64'd1);
            chk("bp_in_ready_full", 64'(In_Ready), 64'd0);
            chk("bp_first_tag", 64'(Out_Tag), 64'd0);
            repeat (5) @(posedge CLK);
            #1 Out_Ready = 1'b1;
         end
      join
      n = 0;
      while (expq.size() != 0 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("bp_output_count", 64'(n_out - base), 64'd6);
      @(posedge CLK); #1;

      // Flush with two ops in flight and a new op offered in the same cycle
      send(64'hAAAA, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd20);
      send(64'hBBBB, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd21);
      Flush = 1'b1; In_Valid = 1'b1; Src1 = 64'hCCCC; Src2 = 6'd3; In_Tag = 5'd22;
      @(negedge CLK);
      chk("flush_in_ready", 64'(In_Ready), 64'd0);
      @(posedge CLK); #1;
      Flush = 1'b0; In_Valid = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge CLK);
         if (Out_Valid) seen++;
      end
      chk("flush_no_outputs", 64'(seen), 64'd0);
      @(posedge CLK); #1;
      run_one("after_flush", 64'h00F0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 64'h000F);

      // Reset with a stalled result sitting at the output
      Out_Ready = 1'b0;
      send(64'h1234, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7);
      send(64'h5678, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8);
      send(64'h9ABC, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9);
      @(negedge CLK);
      chk("prerst_result", Result, 64'h1234);
      @(posedge CLK); #1;
      RST = 1'b1; Out_Ready = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_mid_out_valid", 64'(Out_Valid), 64'd0);
      chk("rst_mid_result", Result, 64'd0);
      chk("rst_mid_in_ready", 64'(In_Ready), 64'd1);
      @(posedge CLK); #1;

      // Randomized traffic with random consumer backpressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               logic [5:0] amt;
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge CLK); #1;
               end
               case ($urandom_range(0, 5))
                  0:       amt = 6'd0;
                  1:       amt = 6'd63;
                  default: amt = 6'($urandom);
               endcase
               send({$urandom, $urandom}, amt, 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 5'(i));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge CLK); #1;
               Out_Ready = ($urandom_range(0, 3) != 0);
            end
            Out_Ready = 1'b1;
         end
      join
      n = 0;
      while (expq.size() != 0 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("drain_empty", 64'(expq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
